// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the ALU arbiter.
//   - ALU op codes 0xA..0xE, with a helper that says whether an op code is legal
//   - FSM state encoding for alu_arbiter
//   - common word type
package calc_pkg;

   typedef logic [15:0] word_t;

   localparam logic [3:0] OP_ADD = 4'hA;
   localparam logic [3:0] OP_SUB = 4'hB;
   localparam logic [3:0] OP_AND = 4'hC;
   localparam logic [3:0] OP_OR  = 4'hD;
   localparam logic [3:0] OP_XOR = 4'hE;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // The legal op codes form one contiguous range, OP_ADD..OP_XOR.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker. This block is combinational only.
//   req0, req1 : request levels
//   ptr        : selects the preferred requester when both request (0 or 1)
//   gnt[1:0]   : one-hot pick, or zero when there is no request
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req0 && req1) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end else if (req0) begin
         gnt = 2'b01;
      end else if (req1) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: gives two requesters shared access to one ALU with a fixed latency.
//   IN_clk, IN_reset (async, active-high)
//   IN_reqN / IN_srcN / IN_dstN / IN_opN : requester N, operation request and operands
//   OUT_gntN  : one-cycle accept pulse        OUT_doneN : one-cycle completion pulse
//   OUT_ans / OUT_err : result and illegal-op flag, read together with a done pulse
//   OUT_busy  : high while the arbiter is not idle
//   OUT_alu_src / OUT_alu_dst / OUT_ALU_OP / OUT_alu_start : ALU launch side
//   IN_alu_ans : ALU result, valid ALU_LAT cycles after OUT_alu_start
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | sample requests; latch the winner's operands and op code
// ISSUE    | grant pulse; ALU launch when the op code is legal
// WAIT     | count down ALU_LAT cycles; capture IN_alu_ans on the last
// DONE     | done pulse to the winner; move the round-robin pointer
module alu_arbiter
   import calc_pkg::*;
#(
   parameter int ALU_LAT = 3
) (
   input  logic        IN_clk,
   input  logic        IN_reset,
   input  logic        IN_req0,
   input  logic        IN_req1,
   input  logic [15:0] IN_src0,
   input  logic [15:0] IN_src1,
   input  logic [15:0] IN_dst0,
   input  logic [15:0] IN_dst1,
   input  logic [3:0]  IN_op0,
   input  logic [3:0]  IN_op1,
   output logic        OUT_gnt0,
   output logic        OUT_gnt1,
   output logic        OUT_done0,
   output logic        OUT_done1,
   output logic [15:0] OUT_ans,
   output logic        OUT_err,
   output logic        OUT_busy,
   output logic [15:0] OUT_alu_src,
   output logic [15:0] OUT_alu_dst,
   output logic [3:0]  OUT_ALU_OP,
   output logic        OUT_alu_start,
   input  logic [15:0] IN_alu_ans
);

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       ptr;
   logic       win;
   logic [1:0] pick;
   word_t      sel_src;
   word_t      sel_dst;
   logic [3:0] sel_op;

   rr_arb2 u_rr_arb2 (
      .req0 (IN_req0),
      .req1 (IN_req1),
      .ptr  (ptr),
      .gnt  (pick)
   );

   assign sel_src = pick[1] ? IN_src1 : IN_src0;
   assign sel_dst = pick[1] ? IN_dst1 : IN_dst0;
   assign sel_op  = pick[1] ? IN_op1  : IN_op0;

   always_ff @(posedge IN_clk or posedge IN_reset) begin
      if (IN_reset) begin
         state         <= ST_IDLE;
         cnt           <= 4'd0;
         ptr           <= 1'b0;
         win           <= 1'b0;
         OUT_gnt0      <= 1'b0;
         OUT_gnt1      <= 1'b0;
         OUT_done0     <= 1'b0;
         OUT_done1     <= 1'b0;
         OUT_ans       <= '0;
         OUT_err       <= 1'b0;
         OUT_busy      <= 1'b0;
         OUT_alu_src   <= '0;
         OUT_alu_dst   <= '0;
         OUT_ALU_OP    <= '0;
         OUT_alu_start <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|pick) begin
                  // Grant and launch are registered here so that both pulses
                  // appear in the ISSUE cycle.
                  win           <= pick[1];
                  OUT_alu_src   <= sel_src;
                  OUT_alu_dst   <= sel_dst;
                  OUT_ALU_OP    <= sel_op;
                  OUT_gnt0      <= pick[0];
                  OUT_gnt1      <= pick[1];
                  OUT_alu_start <= is_legal_op(sel_op);
                  OUT_busy      <= 1'b1;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               OUT_gnt0      <= 1'b0;
               OUT_gnt1      <= 1'b0;
               OUT_alu_start <= 1'b0;
               if (is_legal_op(OUT_ALU_OP)) begin
                  cnt   <= LAT_LOAD;
                  state <= ST_WAIT;
               end else begin
                  OUT_ans   <= '0;
                  OUT_err   <= 1'b1;
                  OUT_done0 <= ~win;
                  OUT_done1 <= win;
                  state     <= ST_DONE;
               end
            end
            ST_WAIT: begin
               // The terminal count of 1 marks the last WAIT cycle, so the
               // counter value gives the number of WAIT cycles still to run.
               if (cnt == 4'd1) begin
                  cnt       <= 4'd0;
                  OUT_ans   <= IN_alu_ans;
                  OUT_err   <= 1'b0;
                  OUT_done0 <= ~win;
                  OUT_done1 <= win;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               OUT_done0 <= 1'b0;
               OUT_done1 <= 1'b0;
               OUT_busy  <= 1'b0;
               ptr       <= ~win;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: ALU_LAT = 3
   logic        rst_a = 1'b0;
   logic        req0_a = 1'b0, req1_a = 1'b0;
   logic [15:0] src0_a = '0, src1_a = '0, dst0_a = '0, dst1_a = '0;
   logic [3:0]  op0_a = '0, op1_a = '0;
   logic        gnt0_a, gnt1_a, done0_a, done1_a, err_a, busy_a, start_a;
   logic [15:0] ans_a, asrc_a, adst_a, alu_ans_a;
   logic [3:0]  aop_a;

   // DUT B: ALU_LAT = 1
   logic        rst_b = 1'b0;
   logic        req0_b = 1'b0, req1_b = 1'b0;
   logic [15:0] src0_b = '0, src1_b = '0, dst0_b = '0, dst1_b = '0;
   logic [3:0]  op0_b = '0, op1_b = '0;
   logic        gnt0_b, gnt1_b, done0_b, done1_b, err_b, busy_b, start_b;
   logic [15:0] ans_b, asrc_b, adst_b, alu_ans_b;
   logic [3:0]  aop_b;

   alu_arbiter #(.ALU_LAT(3)) u_dut_a (
      .IN_clk(clk), .IN_reset(rst_a),
      .IN_req0(req0_a), .IN_req1(req1_a),
      .IN_src0(src0_a), .IN_src1(src1_a), .IN_dst0(dst0_a), .IN_dst1(dst1_a),
      .IN_op0(op0_a), .IN_op1(op1_a),
      .OUT_gnt0(gnt0_a), .OUT_gnt1(gnt1_a), .OUT_done0(done0_a), .OUT_done1(done1_a),
      .OUT_ans(ans_a), .OUT_err(err_a), .OUT_busy(busy_a),
      .OUT_alu_src(asrc_a), .OUT_alu_dst(adst_a), .OUT_ALU_OP(aop_a),
      .OUT_alu_start(start_a), .IN_alu_ans(alu_ans_a)
   );

   alu_arbiter #(.ALU_LAT(1)) u_dut_b (
      .IN_clk(clk), .IN_reset(rst_b),
      .IN_req0(req0_b), .IN_req1(req1_b),
      .IN_src0(src0_b), .IN_src1(src1_b), .IN_dst0(dst0_b), .IN_dst1(dst1_b),
      .IN_op0(op0_b), .IN_op1(op1_b),
      .OUT_gnt0(gnt0_b), .OUT_gnt1(gnt1_b), .OUT_done0(done0_b), .OUT_done1(done1_b),
      .OUT_ans(ans_b), .OUT_err(err_b), .OUT_busy(busy_b),
      .OUT_alu_src(asrc_b), .OUT_alu_dst(adst_b), .OUT_ALU_OP(aop_b),
      .OUT_alu_start(start_b), .IN_alu_ans(alu_ans_b)
   );

   // ALU models: the sum is driven only in the cycle ALU_LAT after the launch
   // cycle, and garbage is driven in every other cycle.
   int acnt_a = 0, acnt_b = 0;
   always @(posedge clk or posedge rst_a)
      if (rst_a) acnt_a <= 0;
      else if (start_a) acnt_a <= 1;
      else if (acnt_a != 0) acnt_a <= (acnt_a == 3) ? 0 : acnt_a + 1;
   always @(posedge clk or posedge rst_b)
      if (rst_b) acnt_b <= 0;
      else if (start_b) acnt_b <= 1;
      else acnt_b <= 0;
   assign alu_ans_a = (acnt_a == 3) ? 16'(asrc_a + adst_a) : 16'hDEAD;
   assign alu_ans_b = (acnt_b == 1) ? 16'(asrc_b + adst_b) : 16'hBEEF;

   int n_cmp = 0, n_mis = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] outs_a();
      return {5'd0, gnt0_a, gnt1_a, done0_a, done1_a, err_a, busy_a, start_a,
              ans_a, asrc_a, adst_a, aop_a};
   endfunction

   task automatic reset_a();
      req0_a = 0; req1_a = 0;
      rst_a = 1;
      #1 chk("reset_outputs_zero", outs_a(), 64'd0);
      tick();
      tick();
      chk("reset_held_zero", outs_a(), 64'd0);
      rst_a = 0;
   endtask

   // Runs one request on DUT A. Cycle 0 is the current cycle, or the next
   // cycle when pre is set.
   task automatic run_a(input bit pre, input bit sel, input logic [15:0] s, input logic [15:0] d,
                        input logic [3:0] o, output int gc, output int dc,
                        output logic [15:0] ans, output bit err, output bit st);
      if (pre) tick();
      if (sel) begin req1_a = 1; src1_a = s; dst1_a = d; op1_a = o; end
      else     begin req0_a = 1; src0_a = s; dst0_a = d; op0_a = o; end
      gc = -1; dc = -1; ans = 'x; err = 0; st = 0;
      for (int c = 1; c <= 25 && dc < 0; c++) begin
         tick();
         chk("other_side_quiet", sel ? {gnt0_a, done0_a} : {gnt1_a, done1_a}, 0);
         if ((sel ? gnt1_a : gnt0_a) && gc < 0) begin
            gc = c; st = start_a;
            if (sel) req1_a = 0; else req0_a = 0;
         end
         if (sel ? done1_a : done0_a) begin
            dc = c; ans = ans_a; err = err_a;
         end
      end
   endtask

   typedef struct {
      bit          sel;
      logic [15:0] src, dst;
      logic [3:0]  op;
      logic [15:0] ans;
      bit          err;
      int          done_c;
      bit          start;
   } vec_t;

   localparam int NC = 1500;
   localparam int NA = NC + 32;
   bit          e_gnt  [0:1][0:NA-1];
   bit          e_done [0:1][0:NA-1];
   bit          e_start[0:NA-1];
   bit          e_busy [0:NA-1];
   bit          e_isd  [0:NA-1];
   bit          e_err  [0:NA-1];
   logic [15:0] e_ans  [0:NA-1];
   bit          e_new  [0:NA-1];
   logic [15:0] e_src  [0:NA-1];
   logic [15:0] e_dst  [0:NA-1];
   logic [3:0]  e_op   [0:NA-1];

   initial begin
      vec_t tbl[9];
      int gc, dc;
      logic [15:0] ans;
      bit err, st;

      tbl[0] = '{0, 16'd12,    16'd34,    4'hA, 16'd46,    0, 5, 1};
      tbl[1] = '{1, 16'd7,     16'd9,     4'h5, 16'd0,     1, 2, 0};
      tbl[2] = '{0, 16'hFFFF,  16'd2,     4'hE, 16'd1,     0, 5, 1};
      tbl[3] = '{1, 16'd100,   16'd200,   4'hB, 16'd300,   0, 5, 1};
      tbl[4] = '{1, 16'd1234,  16'd4321,  4'hC, 16'd5555,  0, 5, 1};
      tbl[5] = '{0, 16'hAAAA,  16'h5555,  4'hD, 16'hFFFF,  0, 5, 1};
      tbl[6] = '{0, 16'd3,     16'd4,     4'hF, 16'd0,     1, 2, 0};
      tbl[7] = '{1, 16'd0,     16'd0,     4'h0, 16'd0,     1, 2, 0};
      tbl[8] = '{0, 16'd1,     16'd1,     4'h9, 16'd0,     1, 2, 0};

      rst_b = 1;
      #2;
      reset_a();

      // Single-request table
      for (int i = 0; i < 9; i++) begin
         run_a(0, tbl[i].sel, tbl[i].src, tbl[i].dst, tbl[i].op, gc, dc, ans, err, st);
         chk($sformatf("v%0d_gnt_cycle", i), gc, 1);
         chk($sformatf("v%0d_alu_start", i), st, tbl[i].start);
         chk($sformatf("v%0d_done_cycle", i), dc, tbl[i].done_c);
         chk($sformatf("v%0d_ans", i), ans, tbl[i].ans);
         chk($sformatf("v%0d_err", i), err, tbl[i].err);
         tick();
         chk($sformatf("v%0d_ans_held_idle", i), {busy_a, ans_a}, {1'b0, tbl[i].ans});
      end

      // Both requesters together right after reset
      begin
         int g0, g1, d0, d1;
         logic [15:0] a1;
         reset_a();
         g0 = -1; g1 = -1; d0 = -1; d1 = -1; a1 = 'x;
         req0_a = 1; src0_a = 1;  dst0_a = 2;  op0_a = 4'hA;
         req1_a = 1; src1_a = 10; dst1_a = 20; op1_a = 4'hB;
         for (int c = 1; c <= 20; c++) begin
            tick();
            if (gnt0_a && g0 < 0) begin g0 = c; req0_a = 0; end
            if (gnt1_a && g1 < 0) begin g1 = c; req1_a = 0; end
            if (done0_a && d0 < 0) d0 = c;
            if (done1_a && d1 < 0) begin d1 = c; a1 = ans_a; end
         end
         chk("both_gnt0_cycle", g0, 1);
         chk("both_done0_cycle", d0, 5);
         chk("both_gnt1_cycle", g1, 7);
         chk("both_done1_cycle", d1, 11);
         chk("both_done1_ans", a1, 30);
      end

      // Both held for four operations
      begin
         int gq[$];
         int gcq[$];
         int dual, ndone, bad_ans;
         reset_a();
         dual = 0; ndone = 0; bad_ans = 0;
         req0_a = 1; src0_a = 5;   dst0_a = 6;   op0_a = 4'hA;
         req1_a = 1; src1_a = 500; dst1_a = 600; op1_a = 4'hA;
         for (int c = 1; c <= 40 && ndone < 4; c++) begin
            tick();
            if ((gnt0_a && gnt1_a) || (done0_a && done1_a)) dual++;
            if (gnt0_a) begin gq.push_back(0); gcq.push_back(c); end
            if (gnt1_a) begin gq.push_back(1); gcq.push_back(c); end
            if (done0_a || done1_a) begin
               ndone++;
               if (ans_a != (done0_a ? 16'd11 : 16'd1100)) bad_ans++;
            end
         end
         req0_a = 0; req1_a = 0;
         chk("held_ops_done", ndone, 4);
         chk("held_dual_pulses", dual, 0);
         chk("held_bad_ans", bad_ans, 0);
         chk("held_gnt_count", gq.size(), 4);
         if (gq.size() == 4) begin
            chk("held_grant_order", {gq[0][0], gq[1][0], gq[2][0], gq[3][0]}, 4'b0101);
            chk("held_grant_cycles", {8'(gcq[0]), 8'(gcq[1]), 8'(gcq[2]), 8'(gcq[3])},
                {8'd1, 8'd7, 8'd13, 8'd19});
         end
      end

      // A request dropped before grant has no effect
      begin
         int saw1, d0;
         saw1 = 0; d0 = -1;
         tick();
         req0_a = 1; src0_a = 2; dst0_a = 3; op0_a = 4'hC;
         for (int c = 1; c <= 14; c++) begin
            tick();
            if (gnt0_a) req0_a = 0;
            if (c == 2) begin req1_a = 1; src1_a = 9; dst1_a = 9; op1_a = 4'hA; end
            if (c == 4) req1_a = 0;
            if (gnt1_a) saw1++;
            if (done0_a) d0 = c;
         end
         chk("drop_done0_cycle", d0, 5);
         chk("drop_no_gnt1", saw1, 0);
         chk("drop_stays_idle", busy_a, 0);
      end

      // Reset during the second WAIT cycle
      begin
         tick();
         req0_a = 1; src0_a = 5; dst0_a = 6; op0_a = 4'hA;
         tick();
         chk("rst_mid_gnt0", {gnt0_a, start_a}, 2'b11);
         req0_a = 0;
         tick();
         tick();
         chk("rst_mid_in_wait", {busy_a, done0_a}, 2'b10);
         #2 rst_a = 1;
         #1 chk("rst_mid_async_zero", outs_a(), 64'd0);
         tick();
         tick();
         chk("rst_mid_held_zero", outs_a(), 64'd0);
         rst_a = 0;
         run_a(0, 1, 16'd40, 16'd2, 4'hA, gc, dc, ans, err, st);
         chk("rst_after_gnt1_cycle", gc, 1);
         chk("rst_after_done1_cycle", dc, 5);
         chk("rst_after_ans", {err, ans}, {1'b0, 16'd42});
      end

      // ALU_LAT = 1 with a 16-bit wrap
      begin
         int g, d;
         logic [15:0] a;
         bit s, e;
         g = -1; d = -1; a = 'x; s = 0; e = 1;
         #2 chk("b_reset_zero", {gnt0_b, done0_b, busy_b, ans_b}, 0);
         tick();
         rst_b = 0;
         req0_b = 1; src0_b = 16'hFFFF; dst0_b = 16'd1; op0_b = 4'hA;
         for (int c = 1; c <= 10 && d < 0; c++) begin
            tick();
            if (gnt0_b && g < 0) begin g = c; s = start_b; req0_b = 0; end
            if (done0_b) begin d = c; a = ans_b; e = err_b; end
         end
         chk("lat1_gnt_cycle", {s, 8'(g)}, {1'b1, 8'd1});
         chk("lat1_done_cycle", d, 3);
         chk("lat1_ans_wrap", {e, a}, {1'b0, 16'd0});
      end

      // Randomized traffic against a transaction-level schedule model
      begin
         bit          pend[2];
         logic [15:0] rs[2], rd[2];
         logic [3:0]  ro[2];
         int          next_sample;
         bit          mptr;
         logic [15:0] m_ans, m_src, m_dst;
         logic [3:0]  m_op;
         reset_a();
         pend[0] = 0; pend[1] = 0;
         rs[0] = 0; rs[1] = 0; rd[0] = 0; rd[1] = 0; ro[0] = 0; ro[1] = 0;
         next_sample = 0; mptr = 0;
         m_ans = 0; m_src = 0; m_dst = 0; m_op = 0;
         for (int t = 0; t < NC; t++) begin
            if (e_new[t]) begin m_src = e_src[t]; m_dst = e_dst[t]; m_op = e_op[t]; end
            if (e_isd[t]) m_ans = e_ans[t];
            chk($sformatf("rnd_pulses@%0d", t),
                {gnt0_a, gnt1_a, done0_a, done1_a, start_a, busy_a},
                {e_gnt[0][t], e_gnt[1][t], e_done[0][t], e_done[1][t], e_start[t], e_busy[t]});
            chk($sformatf("rnd_ans@%0d", t), ans_a, m_ans);
            chk($sformatf("rnd_alu_side@%0d", t), {asrc_a, adst_a, aop_a}, {m_src, m_dst, m_op});
            if (e_isd[t]) chk($sformatf("rnd_err@%0d", t), err_a, e_err[t]);

            for (int n = 0; n < 2; n++) begin
               if (e_gnt[n][t]) pend[n] = 0;
               if (!pend[n]) begin
                  if ($urandom_range(0, 99) < 35) begin
                     int v;
                     pend[n] = 1;
                     rs[n] = 16'($urandom);
                     rd[n] = 16'($urandom);
                     v = $urandom_range(0, 10);
                     ro[n] = ($urandom_range(0, 99) < 75) ? 4'($urandom_range(10, 14))
                                                           : ((v == 10) ? 4'hF : 4'(v));
                  end
               end else if ($urandom_range(0, 99) < 4) begin
                  pend[n] = 0;
               end
            end
            req0_a = pend[0]; src0_a = rs[0]; dst0_a = rd[0]; op0_a = ro[0];
            req1_a = pend[1]; src1_a = rs[1]; dst1_a = rd[1]; op1_a = ro[1];

            if (t >= next_sample && (pend[0] || pend[1])) begin
               int w, g, d;
               bit legal;
               w = (pend[0] && pend[1]) ? int'(mptr) : (pend[1] ? 1 : 0);
               legal = (ro[w] >= 10) && (ro[w] <= 14);
               g = t + 1;
               d = legal ? t + 3 + 2 : t + 2;
               e_gnt[w][g] = 1;
               e_start[g] = legal;
               e_new[g] = 1; e_src[g] = rs[w]; e_dst[g] = rd[w]; e_op[g] = ro[w];
               for (int k = g; k <= d; k++) e_busy[k] = 1;
               e_done[w][d] = 1;
               e_isd[d] = 1;
               e_ans[d] = legal ? 16'(rs[w] + rd[w]) : 16'd0;
               e_err[d] = !legal;
               next_sample = d + 1;
               mptr = (w == 0);
            end
            tick();
         end
         req0_a = 0; req1_a = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
